// File: rtl/sramlike_pkg.sv
// Shared definitions for the sram-like req/addr_ok/data_ok interface.
// Used by the memory responder as well as the caches and bridges that
// drive the same interface.
//   SIZE_*      encodings of the 2-bit size field (3 behaves as a word)
//   sram_state_e  responder FSM state encoding
//   wstrb()     byte-lane strobes derived from size and addr[1:0]
package sramlike_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } sram_state_e;

  // Write data arrives already lane-aligned, so only the strobes depend on
  // the low address bits. Misaligned halfwords are not faulted: addr[0] is
  // simply ignored.
  function automatic logic [3:0] wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sp_ram_bytewe.sv
// Single-port 32-bit RAM with four byte write enables and a synchronous,
// registered read port; written in the template that maps onto block RAM.
//   clk    clock
//   en     access enable for this cycle
//   we     byte write enables; a read is performed when en=1 and we=0
//   addr   word index
//   wdata  write data, lane-aligned
//   rdata  read data, valid the cycle after a read and held until the next read
module sp_ram_bytewe #(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  // NOTE: the array and its output register carry no reset on purpose; a
  // reset term would prevent block-RAM mapping, and the contents are
  // expected to survive a reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sramlike_mem_responder.sv
// Responder end of the sram-like interface: serves one word-addressed
// transaction at a time from a byte-writable on-chip RAM, with programmable
// address (ADDR_LAT) and data (DATA_LAT, 1..15) wait states.
//   clk      clock
//   rst      synchronous active-high reset
//   req      request valid, held with wr/size/addr/wdata until addr_ok
//   wr       1 = write, 0 = read
//   size     0 byte, 1 halfword, 2/3 word
//   addr     byte address; bits above the RAM index alias
//   wdata    lane-aligned write data
//   rdata    response data, valid with data_ok, held afterwards
//   addr_ok  request accepted when req & addr_ok at posedge
//   data_ok  one-cycle response pulse, DATA_LAT cycles after acceptance
module sramlike_mem_responder
  import sramlike_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    ADDR_LAT   = 0,
  parameter int    DATA_LAT   = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  localparam int                ACNT_W    = (ADDR_LAT < 1) ? 1 : $clog2(ADDR_LAT + 1);
  localparam logic [ACNT_W-1:0] ACNT_MAX  = ACNT_W'(ADDR_LAT);
  localparam logic [3:0]        DCNT_INIT = 4'(DATA_LAT - 1);

  sram_state_e       state_q, state_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic              wr_q, wr_d;
  logic [31:0]       rhold_q, rhold_d;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;
  logic [31:0]       resp_data;
  logic              unused_addr_hi;

  // Upper address bits alias by design.
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  sp_ram_bytewe #(
    .ADDR_W    (DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr[DEPTH_LOG2+1:2]),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    acnt_d    = acnt_q;
    dcnt_d    = dcnt_q;
    wr_d      = wr_q;
    rhold_d   = rhold_q;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    resp_data = wr_q ? 32'h0 : ram_rdata;

    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst so a request held through reset is never acknowledged.
        addr_ok = req & ~rst & (acnt_q == ACNT_MAX);
        if (!req) begin
          acnt_d = '0;
        end else if (addr_ok) begin
          // Writes commit here, so any later read sees them without forwarding.
          acnt_d  = '0;
          wr_d    = wr;
          ram_en  = 1'b1;
          ram_we  = wr ? wstrb(size, addr[1:0]) : 4'b0000;
          dcnt_d  = DCNT_INIT;
          state_d = (DATA_LAT > 1) ? ST_WAIT : ST_RESP;
        end else if (acnt_q != ACNT_MAX) begin
          acnt_d = acnt_q + ACNT_W'(1);
        end
      end
      ST_WAIT: begin
        dcnt_d = dcnt_q - 4'd1;
        if (dcnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        data_ok = 1'b1;
        rhold_d = resp_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The RAM output register already holds the read word during RESP (and
  // nothing re-reads the RAM before then); afterwards the captured copy
  // keeps rdata stable until the next response.
  assign rdata = (state_q == ST_RESP) ? resp_data : rhold_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      wr_q    <= 1'b0;
      rhold_q <= '0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      wr_q    <= wr_d;
      rhold_q <= rhold_d;
    end
  end

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Directed bench for sramlike_mem_responder. Three instances cover the
// parameter sets needed: a (ADDR_LAT 0, DATA_LAT 3), b (ADDR_LAT 2,
// DATA_LAT 1), c (ADDR_LAT 0, DATA_LAT 1). Inputs change 1ns after posedge,
// outputs are sampled on negedge.
module tb_sramlike_mem_responder;
  import sramlike_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_a, req_b, req_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        addr_ok_a, addr_ok_b, addr_ok_c;
  logic        data_ok_a, data_ok_b, data_ok_c;

  int n_checks = 0;
  int n_errors = 0;

  sramlike_mem_responder #(.DEPTH_LOG2(10), .ADDR_LAT(0), .DATA_LAT(3)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .addr_ok(addr_ok_a), .data_ok(data_ok_a)
  );

  sramlike_mem_responder #(.DEPTH_LOG2(10), .ADDR_LAT(2), .DATA_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .addr_ok(addr_ok_b), .data_ok(data_ok_b)
  );

  sramlike_mem_responder #(.DEPTH_LOG2(10), .ADDR_LAT(0), .DATA_LAT(1)) u_dut_c (
    .clk(clk), .rst(rst), .req(req_c), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata_c), .addr_ok(addr_ok_c), .data_ok(data_ok_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic aok(input int s);
    return (s == 0) ? addr_ok_a : (s == 1) ? addr_ok_b : addr_ok_c;
  endfunction

  function automatic logic dok(input int s);
    return (s == 0) ? data_ok_a : (s == 1) ? data_ok_b : data_ok_c;
  endfunction

  function automatic logic [31:0] rdat(input int s);
    return (s == 0) ? rdata_a : (s == 1) ? rdata_b : rdata_c;
  endfunction

  task automatic set_req(input int s, input logic v);
    case (s)
      0:       req_a = v;
      1:       req_b = v;
      default: req_c = v;
    endcase
  endtask

  // One transaction. acc = request cycle in which addr_ok was seen (1 = first),
  // lat = cycles from acceptance edge to the data_ok cycle; 0 means timed out.
  task automatic do_txn(input int s, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        output int acc, output int lat, output logic [31:0] rd);
    acc = 0;
    lat = 0;
    rd  = '0;
    wr = w; size = sz; addr = a; wdata = d;
    set_req(s, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (aok(s)) begin
        acc = i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set_req(s, 1'b0);
    if (acc == 0) return;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dok(s)) begin
        lat = i;
        rd  = rdat(s);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic txn_check(input string tag, input int s, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d,
                           input int exp_acc, input int exp_lat, input logic [31:0] exp_rd);
    int acc, lat;
    logic [31:0] rd;
    do_txn(s, w, sz, a, d, acc, lat, rd);
    check({tag, "_accept"}, acc, exp_acc);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    logic [31:0] exp5 [3];
    int          n_acc;
    logic        was_aok;

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    wr = 1'b0; size = SIZE_WORD; addr = '0; wdata = '0;
    @(posedge clk); #1;

    // 1. Reset held with a request pending, then first accept right after.
    wr = 1'b1; size = SIZE_WORD; addr = 32'h0; wdata = 32'h1111_2222;
    req_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t1_rst_addr_ok_%0d", i), addr_ok_c, 1'b0);
      check($sformatf("t1_rst_data_ok_%0d", i), data_ok_c, 1'b0);
      check($sformatf("t1_rst_rdata_%0d", i), rdata_c, 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("t1_first_accept", addr_ok_c, 1'b1);
    @(posedge clk); #1;
    req_c = 1'b0;
    @(negedge clk);
    check("t1_write_data_ok", data_ok_c, 1'b1);
    check("t1_write_rdata", rdata_c, 32'h0);
    @(posedge clk); #1;

    // 2. Word write/read with DATA_LAT=3, plus address aliasing.
    txn_check("t2_wr_10", 0, 1'b1, SIZE_WORD, 32'h10, 32'hDEAD_BEEF, 1, 3, 32'h0);
    txn_check("t2_rd_10", 0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 1, 3, 32'hDEAD_BEEF);
    txn_check("t2_rd_1010", 0, 1'b0, SIZE_WORD, 32'h1010, 32'h0, 1, 3, 32'hDEAD_BEEF);

    // 3. Sub-word writes and size 3 acting as a word.
    txn_check("t3_wr_20", 0, 1'b1, SIZE_WORD, 32'h20, 32'h0, 1, 3, 32'h0);
    txn_check("t3_wb_23", 0, 1'b1, SIZE_BYTE, 32'h23, 32'hAA00_0000, 1, 3, 32'h0);
    txn_check("t3_wh_20", 0, 1'b1, SIZE_HALF, 32'h20, 32'h0000_1234, 1, 3, 32'h0);
    txn_check("t3_rd_20", 0, 1'b0, SIZE_WORD, 32'h20, 32'h0, 1, 3, 32'hAA00_1234);
    txn_check("t3_ws3_2b", 0, 1'b1, 2'd3, 32'h2B, 32'h0102_0304, 1, 3, 32'h0);
    txn_check("t3_rd_28", 0, 1'b0, SIZE_WORD, 32'h28, 32'h0, 1, 3, 32'h0102_0304);

    // 4. ADDR_LAT=2: a dropped request restarts the count.
    wr = 1'b1; size = SIZE_WORD; addr = 32'h4; wdata = 32'hCAFE_0004;
    req_b = 1'b1;
    @(negedge clk);
    check("t4_drop_c1_addr_ok", addr_ok_b, 1'b0);
    @(posedge clk); #1;
    req_b = 1'b0;
    @(negedge clk);
    check("t4_drop_c2_addr_ok", addr_ok_b, 1'b0);
    @(posedge clk); #1;
    txn_check("t4_wr_4", 1, 1'b1, SIZE_WORD, 32'h4, 32'hCAFE_0004, 3, 1, 32'h0);
    txn_check("t4_rd_4", 1, 1'b0, SIZE_WORD, 32'h4, 32'h0, 3, 1, 32'hCAFE_0004);

    // 5. Back-to-back reads with req held high, DATA_LAT=1.
    exp5[0] = 32'h0A0A_0001;
    exp5[1] = 32'h0B0B_0002;
    exp5[2] = 32'h0C0C_0003;
    for (int k = 0; k < 3; k++) begin
      txn_check($sformatf("t5_pre_%0d", k), 2, 1'b1, SIZE_WORD, 32'h100 + 32'(4 * k), exp5[k], 1, 1, 32'h0);
    end
    wr = 1'b0; size = SIZE_WORD; addr = 32'h100;
    req_c = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("t5_addr_ok_%0d", i), addr_ok_c, (i % 2 == 0) && (i < 6));
      check($sformatf("t5_data_ok_%0d", i), data_ok_c, (i % 2 == 1));
      if (data_ok_c && ((i - 1) / 2) < 3)
        check($sformatf("t5_rdata_%0d", i), rdata_c, exp5[(i - 1) / 2]);
      was_aok = addr_ok_c;
      @(posedge clk); #1;
      if (was_aok) begin
        n_acc++;
        addr = 32'h100 + 32'(4 * n_acc);
        if (n_acc == 3) req_c = 1'b0;
      end
    end
    check("t5_accept_count", n_acc, 3);

    // 6. Reset while a write waits for its response.
    wr = 1'b1; size = SIZE_WORD; addr = 32'h30; wdata = 32'h0000_0055;
    req_a = 1'b1;
    @(negedge clk);
    check("t6_accept", addr_ok_a, 1'b1);
    @(posedge clk); #1;
    req_a = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("t6_rst_data_ok", data_ok_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t6_no_data_ok_%0d", i), data_ok_a, 1'b0);
      @(posedge clk); #1;
    end
    txn_check("t6_rd_30", 0, 1'b0, SIZE_WORD, 32'h30, 32'h0, 1, 3, 32'h0000_0055);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
